// File: rtl/code_dec_pkg.sv
// Shared definitions for the code-group decoder: default code width,
// output width derivation and the two-state FSM encoding.
package code_dec_pkg;

   localparam int CODE_W_DEF = 3;

   function automatic int out_width(input int code_w);
      return 1 << code_w;
   endfunction

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_e;

endpackage

// File: rtl/onehot_popcount.sv
// Combinational population count of an OUT_W-bit vector into a CNT_W-bit result.
module onehot_popcount #(
   parameter int OUT_W = 8,
   parameter int CNT_W = 4
) (
   input  logic [OUT_W-1:0] vec,
   output logic [CNT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < OUT_W; i++) begin
         count = count + CNT_W'(vec[i]);
      end
   end

endmodule

// File: rtl/code_group_decoder.sv
// Rebuilds bit vectors from a valid/ready stream of codes, either one code per
// word (single mode) or OR-ed across an in_last-terminated group (accumulate mode).
module code_group_decoder
   import code_dec_pkg::*;
#(
   parameter  int CODE_W = CODE_W_DEF,
   localparam int OUT_W  = out_width(CODE_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_last,
   input  logic              acc_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_vec,
   output logic [CODE_W:0]   out_count,
   output logic              out_dup
);

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   mask_q, mask_d;
   logic               dup_q, dup_d;
   logic               first_q, first_d;
   logic               grp_acc_q, grp_acc_d;
   logic [OUT_W-1:0]   out_vec_q, out_vec_d;
   logic [CODE_W:0]    out_count_q, out_count_d;
   logic               out_dup_q, out_dup_d;

   logic               accept;
   logic               first_beat;
   logic               grp_mode;
   logic               grp_done;
   logic               hit;
   logic [OUT_W-1:0]   code_bit;
   logic [OUT_W-1:0]   merged;
   logic [CODE_W:0]    merged_count;

   // Ready depends only on state and downstream ready, never on in_valid.
   assign in_ready   = rst_n & ((state_q == COLLECT) | out_ready);
   assign accept     = in_valid & in_ready;

   assign code_bit   = OUT_W'(1) << in_code;
   assign hit        = |(mask_q & code_bit);
   assign merged     = mask_q | code_bit;
   assign first_beat = first_q & (mask_q == '0);
   assign grp_mode   = first_beat ? acc_en : grp_acc_q;
   assign grp_done   = ~grp_mode | in_last;

   onehot_popcount #(
      .OUT_W (OUT_W),
      .CNT_W (CODE_W + 1)
   ) u_popcount (
      .vec   (merged),
      .count (merged_count)
   );

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      dup_d       = dup_q;
      first_d     = first_q;
      grp_acc_d   = grp_acc_q;
      out_vec_d   = out_vec_q;
      out_count_d = out_count_q;
      out_dup_d   = out_dup_q;

      if (state_q == EMIT && out_ready) begin
         state_d = COLLECT;
      end

      // A beat taken in EMIT means the pending result is leaving this cycle.
      if (accept) begin
         if (first_beat) begin
            grp_acc_d = acc_en;
         end
         if (grp_done) begin
            out_vec_d   = merged;
            out_count_d = merged_count;
            out_dup_d   = dup_q | hit;
            mask_d      = '0;
            dup_d       = 1'b0;
            first_d     = 1'b1;
            state_d     = EMIT;
         end else begin
            mask_d      = merged;
            dup_d       = dup_q | hit;
            first_d     = 1'b0;
            state_d     = COLLECT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         mask_q      <= '0;
         dup_q       <= 1'b0;
         first_q     <= 1'b1;
         grp_acc_q   <= 1'b0;
         out_vec_q   <= '0;
         out_count_q <= '0;
         out_dup_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         dup_q       <= dup_d;
         first_q     <= first_d;
         grp_acc_q   <= grp_acc_d;
         out_vec_q   <= out_vec_d;
         out_count_q <= out_count_d;
         out_dup_q   <= out_dup_d;
      end
   end

   assign out_valid = (state_q == EMIT);
   assign out_vec   = out_vec_q;
   assign out_count = out_count_q;
   assign out_dup   = out_dup_q;

endmodule
